uart_rx_oversampled: RTL and testbench

UART_RX_OVERSAMPLED -- requirements
Module: uart_rx_oversampled

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_oversampled_if.sv | 13 +
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_rx_oversampled.sv | 135 +++++++++++++
 tb/tb_uart_rx_oversampled.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the oversampled UART receiver.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  // Tick index within a bit period at which the line is taken as mid-bit.
  localparam int MID_SAMPLE_DEF = OVERSAMPLE_DEF / 2 - 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

  function automatic int mid_sample(input int oversample);
    return oversample / 2 - 1;
  endfunction

endpackage

// File: rtl/uart_rx_oversampled_if.sv
// Valid/ready byte output channel of the UART receiver.
interface uart_rx_oversampled_if import uart_pkg::*; #(
  parameter int DATA_BITS = DATA_BITS_DEF
) ();

  logic                 io_valid;
  logic                 io_ready;
  logic [DATA_BITS-1:0] io_bits;

  modport master (output io_valid, output io_bits, input io_ready);
  modport slave  (input io_valid, input io_bits, output io_ready);

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
module uart_rx_sync (
  input  logic clock,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver (8N1, LSB first) with a one-entry valid/ready holding register.
module uart_rx_oversampled import uart_pkg::*; #(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     rx,
  input  logic                     tick,
  uart_rx_oversampled_if.master    io,
  output logic                     frame_err,
  output logic                     overrun
);

  localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(mid_sample(OVERSAMPLE));
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 w_rx;
  logic                 w_bit_end;
  logic                 w_done;
  logic                 w_bad_stop;
  logic                 w_xfer;

  rx_state_e            r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_rx_d;
  logic                 r_valid;
  logic [DATA_BITS-1:0] r_bits;
  logic                 r_frame_err;
  logic                 r_overrun;

  uart_rx_sync u_sync (
    .clock   (clock),
    .reset   (reset),
    .i_async (rx),
    .o_sync  (w_rx)
  );

  assign w_bit_end  = tick && (r_cnt == CNT_LAST);
  assign w_done     = (r_state == ST_STOP) && w_bit_end && w_rx;
  assign w_bad_stop = (r_state == ST_STOP) && w_bit_end && !w_rx;
  assign w_xfer     = r_valid && io.io_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_rx_d  <= 1'b1;
    end else begin
      r_rx_d <= w_rx;
      case (r_state)
        // Start-edge detection runs every clock, not only on ticks.
        ST_IDLE: begin
          if (r_rx_d && !w_rx) begin
            r_state <= ST_START;
            r_cnt   <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (r_cnt == CNT_MID) begin
              r_cnt   <= '0;
              r_idx   <= '0;
              r_state <= w_rx ? ST_IDLE : ST_DATA;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (r_cnt == CNT_LAST) begin
              r_cnt   <= '0;
              r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
              if (r_idx == IDX_LAST) begin
                r_idx   <= '0;
                r_state <= ST_STOP;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (r_cnt == CNT_LAST) begin
              r_cnt   <= '0;
              r_state <= w_rx ? ST_IDLE : ST_WAIT_IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (tick && w_rx) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A byte arriving in a transfer cycle refills the register without a bubble.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid     <= 1'b0;
      r_bits      <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_bad_stop;
      r_overrun   <= w_done && r_valid && !io.io_ready;
      if (w_done && (!r_valid || io.io_ready)) begin
        r_bits  <= r_shift;
        r_valid <= 1'b1;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign io.io_valid = r_valid;
  assign io.io_bits  = r_bits;
  assign frame_err   = r_frame_err;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: directed frames, expected bytes queued, popped on each transfer.
module tb_uart_rx_oversampled;
  import uart_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic rx    = 1'b1;
  logic tick  = 1'b0;
  logic frame_err;
  logic overrun;

  uart_rx_oversampled_if #(.DATA_BITS(8)) io_if ();

  uart_rx_oversampled #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .tick      (tick),
    .io        (io_if.master),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clock = ~clock;

  int tick_div = 1;
  int tick_ph  = 0;

  always @(posedge clock) begin
    #1;
    if (tick_div <= 1) begin
      tick = 1'b1;
    end else begin
      tick    = (tick_ph == 0);
      tick_ph = (tick_ph + 1) % tick_div;
    end
  end

  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  int n_checks   = 0;
  int n_pass     = 0;
  int vld_cycles = 0;
  int err_cycles = 0;
  int ovr_cycles = 0;

  // Monitor: negedge sees the values the next rising edge will capture.
  always @(negedge clock) begin
    if (reset) begin
      if (io_if.io_valid) vld_cycles++;
      if (frame_err) err_cycles++;
      if (overrun) ovr_cycles++;
      if (io_if.io_valid && io_if.io_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL rx_byte: got %02h, required no byte", io_if.io_bits);
        end else begin
          mon_exp = exp_q.pop_front();
          if (io_if.io_bits === mon_exp) n_pass++;
          else $display("FAIL rx_byte: got %02h, required %02h", io_if.io_bits, mon_exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drives start, data (LSB first) and stop; the line is left at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bt);
    rx = 1'b0;
    repeat (bt) step();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bt) step();
    end
    rx = stop_bit;
    repeat (bt) step();
  endtask

  int v0, e0, o0;
  logic [7:0] partial;

  initial begin
    io_if.io_ready = 1'b0;
    repeat (3) step();
    check("rst_io_valid", 32'(io_if.io_valid), 32'd0);
    check("rst_io_bits", 32'(io_if.io_bits), 32'h00);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    reset = 1'b1;
    repeat (5) step();

    // Plain frame, consumer always ready
    io_if.io_ready = 1'b1;
    v0 = vld_cycles; e0 = err_cycles; o0 = ovr_cycles;
    exp_q.push_back(8'h65);
    send_frame(8'h65, 1'b1, 16);
    repeat (20) step();
    check("t65_valid_cycles", 32'(vld_cycles - v0), 32'd1);
    check("t65_frame_err", 32'(err_cycles - e0), 32'd0);
    check("t65_overrun", 32'(ovr_cycles - o0), 32'd0);

    // Short glitch on the line
    v0 = vld_cycles;
    rx = 1'b0;
    repeat (4) step();
    rx = 1'b1;
    repeat (40) step();
    check("glitch_no_valid", 32'(vld_cycles - v0), 32'd0);
    check("glitch_state_idle", 32'(dut.r_state), 32'(ST_IDLE));

    // Bad stop bit, line held low, then a good frame
    v0 = vld_cycles; e0 = err_cycles; o0 = ovr_cycles;
    send_frame(8'hA3, 1'b0, 16);
    repeat (40) step();
    rx = 1'b1;
    repeat (20) step();
    check("ferr_pulse_cycles", 32'(err_cycles - e0), 32'd1);
    check("ferr_no_valid", 32'(vld_cycles - v0), 32'd0);
    check("ferr_no_overrun", 32'(ovr_cycles - o0), 32'd0);
    v0 = vld_cycles;
    exp_q.push_back(8'h5C);
    send_frame(8'h5C, 1'b1, 16);
    repeat (20) step();
    check("after_ferr_valid_cycles", 32'(vld_cycles - v0), 32'd1);

    // Overrun: consumer stalled across two frames
    io_if.io_ready = 1'b0;
    e0 = err_cycles; o0 = ovr_cycles;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 16);
    repeat (20) step();
    check("ovr_first_valid", 32'(io_if.io_valid), 32'd1);
    check("ovr_first_bits", 32'(io_if.io_bits), 32'h11);
    send_frame(8'h22, 1'b1, 16);
    repeat (20) step();
    check("ovr_held_bits", 32'(io_if.io_bits), 32'h11);
    check("ovr_pulse_cycles", 32'(ovr_cycles - o0), 32'd1);
    check("ovr_no_frame_err", 32'(err_cycles - e0), 32'd0);
    io_if.io_ready = 1'b1;
    step();
    io_if.io_ready = 1'b0;
    check("ovr_valid_drops", 32'(io_if.io_valid), 32'd0);

    // Consumer ready exactly in the delivery cycle of the second byte (edge 155 after rx falls)
    o0 = ovr_cycles;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1, 16);
    repeat (20) step();
    check("xfer_first_held", 32'(io_if.io_bits), 32'h11);
    fork
      send_frame(8'h22, 1'b1, 16);
      begin
        repeat (154) step();
        io_if.io_ready = 1'b1;
        step();
        io_if.io_ready = 1'b0;
        check("xfer_valid_kept", 32'(io_if.io_valid), 32'd1);
        check("xfer_new_bits", 32'(io_if.io_bits), 32'h22);
      end
    join
    repeat (10) step();
    check("xfer_no_overrun", 32'(ovr_cycles - o0), 32'd0);
    io_if.io_ready = 1'b1;
    step();
    check("xfer_drain_valid_drops", 32'(io_if.io_valid), 32'd0);

    // Reset in the middle of a frame at 16 clocks per tick
    tick_div = 16;
    partial = 8'h3C;
    rx = 1'b0;
    repeat (256) step();
    for (int i = 0; i < 3; i++) begin
      rx = partial[i];
      repeat (256) step();
    end
    rx = partial[3];
    repeat (128) step();
    reset = 1'b0;
    rx = 1'b1;
    repeat (4) step();
    check("midrst_io_valid", 32'(io_if.io_valid), 32'd0);
    check("midrst_io_bits", 32'(io_if.io_bits), 32'h00);
    check("midrst_state", 32'(dut.r_state), 32'(ST_IDLE));
    reset = 1'b1;
    repeat (512) step();
    check("midrst_idle_after_release", 32'(dut.r_state), 32'(ST_IDLE));
    v0 = vld_cycles; e0 = err_cycles;
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, 256);
    repeat (256) step();
    check("slow_valid_cycles", 32'(vld_cycles - v0), 32'd1);
    check("slow_frame_err", 32'(err_cycles - e0), 32'd0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
